// File: rtl/ram_master_pkg.sv
// Shared types and defaults for the ram_master initiator and its burst counter.
package ram_master_pkg;

  localparam int ADDR_SIZE = 11;
  localparam int WORD_SIZE = 9;
  localparam int LEN_SIZE  = 4;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // RAM pins outside an access: disabled, read-enable parked high so WE/RE never both low
  localparam logic IDLE_EN = 1'b0;
  localparam logic IDLE_WE = 1'b0;
  localparam logic IDLE_RE = 1'b1;

endpackage

// File: rtl/ram_burst_ctr.sv
// Burst address/beat counter: loads start address and beats-minus-one, steps per
// accepted response beat with modulo address wrap; last flags the final beat.
module ram_burst_ctr
  import ram_master_pkg::*;
#(
  parameter int AddrSize = ADDR_SIZE,
  parameter int LenSize  = LEN_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_load,
  input  logic [AddrSize-1:0] i_addr,
  input  logic [LenSize-1:0]  i_len,
  input  logic                i_step,
  output logic [AddrSize-1:0] o_addr,
  output logic                o_last
);

  logic [AddrSize-1:0] r_addr;
  logic [LenSize-1:0]  r_left;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
      r_left <= '0;
    end else if (i_load) begin
      r_addr <= i_addr;
      r_left <= i_len;
    end else if (i_step && (r_left != '0)) begin
      r_addr <= r_addr + AddrSize'(1);
      r_left <= r_left - LenSize'(1);
    end
  end

  assign o_addr = r_addr;
  assign o_last = (r_left == '0);

endmodule

// File: rtl/ram_master.sv
// Valid/ready initiator for the single-port ram: one-cycle writes, registered reads.
// Define RAM_MASTER_BURST_EN to honour req_len on reads (consecutive wrapping addresses).
module ram_master
  import ram_master_pkg::*;
#(
  parameter int AddrSize = ADDR_SIZE,
  parameter int WordSize = WORD_SIZE,
  parameter int LenSize  = LEN_SIZE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [AddrSize-1:0] req_addr,
  input  logic [WordSize-1:0] req_wdata,
  input  logic [LenSize-1:0]  req_len,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [WordSize-1:0] rsp_data,
  output logic [AddrSize-1:0] ram_addr,
  output logic [WordSize-1:0] ram_di,
  input  logic [WordSize-1:0] ram_do,
  output logic                ram_en,
  output logic                ram_we,
  output logic                ram_re,
  output logic                busy
);

  state_t              r_state;
  state_t              w_next;
  logic [WordSize-1:0] r_wdata;
  logic [AddrSize-1:0] w_addr;
  logic                w_last;
  logic                w_accept;
  logic                w_rsp_hs;

  assign w_accept = req_valid && (r_state == ST_IDLE);
  assign w_rsp_hs = rsp_ready && (r_state == ST_RESP);

`ifdef RAM_MASTER_BURST_EN
  logic [LenSize-1:0] w_len;

  assign w_len = req_we ? '0 : req_len;

  ram_burst_ctr #(
    .AddrSize(AddrSize),
    .LenSize (LenSize)
  ) u_burst_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .i_load(w_accept),
    .i_addr(req_addr),
    .i_len (w_len),
    .i_step(w_rsp_hs),
    .o_addr(w_addr),
    .o_last(w_last)
  );
`else
  logic [AddrSize-1:0] r_addr;
  logic                w_unused_len;

  assign w_unused_len = ^req_len;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr <= '0;
    end else if (w_accept) begin
      r_addr <= req_addr;
    end
  end

  assign w_addr = r_addr;
  assign w_last = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // ram_do is only trusted in CAPT, the cycle after the RAM registered it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wdata  <= '0;
      rsp_data <= '0;
    end else begin
      if (w_accept) begin
        r_wdata <= req_wdata;
      end
      if (r_state == ST_CAPT) begin
        rsp_data <= ram_do;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (req_valid) w_next = req_we ? ST_WRITE : ST_READ;
      ST_WRITE: w_next = ST_IDLE;
      ST_READ:  w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_RESP;
      ST_RESP:  if (rsp_ready) w_next = w_last ? ST_IDLE : ST_READ;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    req_ready = 1'b0;
    busy      = 1'b1;
    rsp_valid = 1'b0;
    ram_en    = IDLE_EN;
    ram_we    = IDLE_WE;
    ram_re    = IDLE_RE;
    case (r_state)
      ST_IDLE: begin
        req_ready = 1'b1;
        busy      = 1'b0;
      end
      ST_WRITE: begin
        ram_en = 1'b1;
        ram_we = 1'b1;
        ram_re = 1'b0;
      end
      ST_READ: begin
        ram_en = 1'b1;
        ram_we = 1'b0;
        ram_re = 1'b1;
      end
      ST_RESP: rsp_valid = 1'b1;
      default: ;
    endcase
  end

  assign ram_addr = w_addr;
  assign ram_di   = r_wdata;

endmodule

// File: tb/tb_ram_master.sv
// Self-checking bench for ram_master: table vectors, directed corner sequences,
// and a random request mix scored against a shadow memory model.
module tb_ram_master;

`ifdef RAM_MASTER_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic        clk;
  logic        rst_n = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [10:0] req_addr = '0;
  logic [8:0]  req_wdata = '0;
  logic [3:0]  req_len = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [8:0]  rsp_data;
  logic [10:0] ram_addr;
  logic [8:0]  ram_di;
  logic [8:0]  ram_do;
  logic        ram_en, ram_we, ram_re, busy;

  ram_master dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_len(req_len),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .ram_addr(ram_addr), .ram_di(ram_di), .ram_do(ram_do),
    .ram_en(ram_en), .ram_we(ram_we), .ram_re(ram_re), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM model: registered read, garbage on DO whenever no read happened
  logic [8:0] mem    [0:2047];
  logic [8:0] shadow [0:2047];

  always @(posedge clk) begin
    if (ram_en && ram_we) mem[ram_addr] <= ram_di;
    if (ram_en && ram_re) ram_do <= mem[ram_addr];
    else ram_do <= 9'($urandom);
  end

  // Monitor and scoreboard
  logic [8:0]  exp_q[$];
  logic [10:0] rd_log[$];
  int          hs_cnt = 0, rd_cnt = 0, we_cnt = 0;
  logic [10:0] last_we_addr;
  logic [8:0]  last_we_di;
  bit          rand_rdy = 1'b0;
  bit          rdy_force = 1'b1;
  logic [10:0] a_early;
  logic        en_early;

  always @(posedge clk) begin
    #1;
    a_early  = ram_addr;
    en_early = ram_en;
  end

  always @(negedge clk) begin
    rsp_ready = rand_rdy ? 1'($urandom_range(0, 1)) : rdy_force;
    if (rst_n) begin
      chk("pins_we_xor_re", int'(ram_we ^ ram_re), 1);
      if (ram_en && en_early) chk("addr_stable", int'(ram_addr), int'(a_early));
      chk("req_ready_vs_busy", int'(req_ready), int'(!busy));
      if (ram_en && ram_we) begin
        we_cnt++;
        last_we_addr = ram_addr;
        last_we_di   = ram_di;
      end
      if (ram_en && ram_re) begin
        rd_cnt++;
        rd_log.push_back(ram_addr);
      end
      if (rsp_valid && rsp_ready) begin
        hs_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp", 1, 0);
        end else begin
          chk("rsp_data", int'(rsp_data), int'(exp_q.pop_front()));
        end
      end
    end
  end

  task automatic do_req(input bit we, input logic [10:0] a, input logic [8:0] d,
                        input logic [3:0] l, input bit model);
    int t = 0;
    int nb;
    @(negedge clk);
    while (!req_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) begin
      chk("req_accept_timeout", 0, 1);
      return;
    end
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    req_len   = l;
    @(posedge clk);
    #1 req_valid = 1'b0;
    if (we) begin
      shadow[a] = d;
    end else if (model) begin
      nb = BURST ? int'(l) + 1 : 1;
      for (int i = 0; i < nb; i++) exp_q.push_back(shadow[11'(int'(a) + i)]);
    end
  endtask

  task automatic wait_idle();
    int t = 0;
    @(negedge clk);
    while (busy && t < 1000) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", int'(busy), 0);
  endtask

  typedef struct {
    bit          we;
    logic [10:0] addr;
    logic [8:0]  wdata;
    logic [8:0]  exp;
  } vec_t;

  vec_t tbl[6];

  initial begin
    int b_we, b_hs, b_rd, t;
    logic [8:0] held;

    tbl[0] = '{1'b1, 11'h010, 9'h1A5, 9'h000};
    tbl[1] = '{1'b1, 11'h7FF, 9'h0FF, 9'h000};
    tbl[2] = '{1'b1, 11'h000, 9'h155, 9'h000};
    tbl[3] = '{1'b0, 11'h010, 9'h000, 9'h1A5};
    tbl[4] = '{1'b0, 11'h7FF, 9'h000, 9'h0FF};
    tbl[5] = '{1'b0, 11'h000, 9'h000, 9'h155};

    for (int i = 0; i < 2048; i++) begin
      mem[i]    = 9'($urandom);
      shadow[i] = mem[i];
    end

    #2 rst_n = 1'b0;
    #1;
    chk("rst_req_ready", int'(req_ready), 1);
    chk("rst_rsp_valid", int'(rsp_valid), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_ram_pins", int'({ram_en, ram_we, ram_re}), 1);
    chk("rst_ram_addr", int'(ram_addr), 0);
    repeat (3) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;

    // Table vectors: writes must pulse WE once with the right pins, reads return table data
    foreach (tbl[i]) begin
      b_we = we_cnt;
      b_hs = hs_cnt;
      if (tbl[i].we) begin
        do_req(1'b1, tbl[i].addr, tbl[i].wdata, 4'd0, 1'b0);
        wait_idle();
        chk("tbl_we_pulses", we_cnt - b_we, 1);
        chk("tbl_we_addr", int'(last_we_addr), int'(tbl[i].addr));
        chk("tbl_we_di", int'(last_we_di), int'(tbl[i].wdata));
      end else begin
        exp_q.push_back(tbl[i].exp);
        do_req(1'b0, tbl[i].addr, 9'h000, 4'd0, 1'b0);
        wait_idle();
        chk("tbl_rd_handshakes", hs_cnt - b_hs, 1);
      end
    end

    // Read latency: rsp_valid exactly two edges after accept
    exp_q.push_back(9'h1A5);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 11'h010; req_len = 4'd0;
    @(posedge clk);
    #1 req_valid = 1'b0;
    chk("lat_e0_read_pins", int'({ram_en, ram_we, ram_re}), 5);
    chk("lat_e0_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_e1_en", int'(ram_en), 0);
    chk("lat_e1_rsp_valid", int'(rsp_valid), 0);
    @(posedge clk);
    #1;
    chk("lat_e2_rsp_valid", int'(rsp_valid), 1);
    chk("lat_e2_rsp_data", int'(rsp_data), 'h1A5);
    wait_idle();

    // Stalled response, with a write request pending against the final RESP beat
    rdy_force = 1'b0;
    b_hs = hs_cnt;
    do_req(1'b0, 11'h7FF, 9'h000, 4'd0, 1'b1);
    t = 0;
    while (!rsp_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("stall_rsp_valid_seen", int'(rsp_valid), 1);
    held = rsp_data;
    chk("stall_rsp_data", int'(held), 'h0FF);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 11'h123; req_wdata = 9'h0AA; req_len = 4'd0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("stall_valid_held", int'(rsp_valid), 1);
      chk("stall_data_held", int'(rsp_data), int'(held));
      chk("stall_req_ready_low", int'(req_ready), 0);
    end
    b_we = we_cnt;
    rdy_force = 1'b1;
    t = 0;
    while (!req_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("simul_hs_before_accept", hs_cnt - b_hs, 1);
    chk("simul_rsp_valid_low", int'(rsp_valid), 0);
    @(posedge clk);
    #1 req_valid = 1'b0;
    shadow[11'h123] = 9'h0AA;
    wait_idle();
    chk("simul_write_pulses", we_cnt - b_we, 1);
    chk("simul_write_addr", int'(last_we_addr), 'h123);
    chk("stall_total_hs", hs_cnt - b_hs, 1);

    // Burst across the top of the address space
    b_hs = hs_cnt;
    b_rd = rd_cnt;
    rd_log.delete();
    do_req(1'b0, 11'h7FE, 9'h000, 4'd3, 1'b1);
    wait_idle();
`ifdef RAM_MASTER_BURST_EN
    chk("burst_beats", hs_cnt - b_hs, 4);
    chk("burst_rd_cycles", rd_cnt - b_rd, 4);
    if (rd_log.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("burst_addr_seq", int'(rd_log[i]), int'(11'(32'h7FE + i)));
    end else begin
      chk("burst_addr_log_len", rd_log.size(), 4);
    end
`else
    chk("noburst_rsps", hs_cnt - b_hs, 1);
    chk("noburst_rd_cycles", rd_cnt - b_rd, 1);
`endif

    // Reset during CAPT of beat 2 (beat 1 when bursts are disabled)
    b_rd = rd_cnt;
    do_req(1'b0, 11'h100, 9'h000, 4'd3, 1'b1);
    t = 0;
    while ((rd_cnt - b_rd) < (BURST ? 2 : 1) && t < 50) begin
      @(negedge clk);
      #1;
      t++;
    end
    chk("rst_target_reached", rd_cnt - b_rd, BURST ? 2 : 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req_ready", int'(req_ready), 1);
    chk("arst_rsp_valid", int'(rsp_valid), 0);
    chk("arst_rsp_data", int'(rsp_data), 0);
    chk("arst_busy", int'(busy), 0);
    chk("arst_ram_pins", int'({ram_en, ram_we, ram_re}), 1);
    chk("arst_ram_addr", int'(ram_addr), 0);
    chk("arst_ram_di", int'(ram_di), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    b_hs = hs_cnt; b_rd = rd_cnt; b_we = we_cnt;
    repeat (10) @(negedge clk);
    chk("post_rst_no_rsp", hs_cnt - b_hs, 0);
    chk("post_rst_no_ram", (rd_cnt - b_rd) + (we_cnt - b_we), 0);
    chk("post_rst_req_ready", int'(req_ready), 1);

    // Random request mix against the shadow model
    rand_rdy = 1'b1;
    for (int i = 0; i < 40; i++) begin
      logic [10:0] a;
      a = ($urandom_range(0, 3) == 0) ? 11'(2047 - $urandom_range(0, 2)) : 11'($urandom);
      do_req($urandom_range(0, 2) == 0, a, 9'($urandom), 4'($urandom), 1'b1);
    end
    wait_idle();
    rand_rdy  = 1'b0;
    rdy_force = 1'b1;
    repeat (2) @(negedge clk);
    chk("rand_queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
